dcache: RTL and testbench

DCACHE -- requirements
Module: dcache

---
 rtl/cache_pkg.sv | 30 +++
 rtl/dcache_array.sv | 60 ++++++
 rtl/dcache.sv | 122 ++++++++++++
 tb/tb_dcache.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared cache geometry, address split and controller state encoding.
package cache_pkg;

  localparam int unsigned LINES  = 8;
  localparam int unsigned WORDS  = 4;
  localparam int unsigned TAG_W  = 25;
  localparam int unsigned IDX_W  = 3;
  localparam int unsigned OFF_W  = 2;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned BLK_W  = TAG_W + IDX_W;
  localparam int unsigned LINE_W = WORDS * WORD_W;

  // One cache line; word0 occupies bits [31:0].
  typedef logic [WORDS-1:0][WORD_W-1:0] line_t;

  // Word-granular view of a byte address (byte offset bits dropped).
  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [IDX_W-1:0] idx;
    logic [OFF_W-1:0] off;
  } addr_t;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    ALLOCATE  = 2'd2
  } state_e;

endpackage

// File: rtl/dcache_array.sv
// Tag/valid/dirty/data storage for the direct-mapped cache.
// Ports: clk, rst (sync, clears valid/dirty only); idx selects the line for
// both the combinational read port (rd_*) and the write port. word_we writes
// one word (wr_off, wr_word) and marks the line dirty; line_we installs a
// whole line (wr_tag, wr_line) as valid and clean.
module dcache_array
  import cache_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] idx,
  output logic             rd_valid,
  output logic             rd_dirty,
  output logic [TAG_W-1:0] rd_tag,
  output line_t            rd_line,
  input  logic             word_we,
  input  logic [OFF_W-1:0] wr_off,
  input  logic [WORD_W-1:0] wr_word,
  input  logic             line_we,
  input  logic [TAG_W-1:0] wr_tag,
  input  line_t            wr_line
);

  logic [LINES-1:0] valid_q;
  logic [LINES-1:0] dirty_q;
  logic [TAG_W-1:0] tag_q  [LINES];
  line_t            data_q [LINES];

  // Combinational read port.
  always_comb begin
    rd_valid = valid_q[idx];
    rd_dirty = dirty_q[idx];
    rd_tag   = tag_q[idx];
    rd_line  = data_q[idx];
  end

  // Status bits: the only storage that needs a reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (line_we) begin
      valid_q[idx] <= 1'b1;
      dirty_q[idx] <= 1'b0;
    end else if (word_we) begin
      dirty_q[idx] <= 1'b1;
    end
  end

  // Tag and data arrays, no reset.
  always_ff @(posedge clk) begin
    if (line_we) begin
      tag_q[idx]  <= wr_tag;
      data_q[idx] <= wr_line;
    end else if (word_we) begin
      data_q[idx][wr_off] <= wr_word;
    end
  end

endmodule

// File: rtl/dcache.sv
// Direct-mapped, write-back, write-allocate data cache controller.
// Ports: clk, rst (sync, active-high); processor side proc_ren/proc_wen/
// proc_addr/proc_wdata in, proc_stall/proc_rdata out (combinational);
// memory side mem_read/mem_write/mem_addr/mem_wdata out (registered),
// mem_rdata/mem_ready in.
module dcache
  import cache_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               proc_ren,
  input  logic               proc_wen,
  input  logic [ADDR_W-1:0]  proc_addr,
  input  logic [WORD_W-1:0]  proc_wdata,
  output logic               proc_stall,
  output logic [WORD_W-1:0]  proc_rdata,
  output logic               mem_read,
  output logic               mem_write,
  output logic [BLK_W-1:0]   mem_addr,
  output logic [LINE_W-1:0]  mem_wdata,
  input  logic [LINE_W-1:0]  mem_rdata,
  input  logic               mem_ready
);

  state_e state_q;
  state_e state_n;

  addr_t            a_s;
  logic             rd_valid;
  logic             rd_dirty;
  logic [TAG_W-1:0] rd_tag;
  line_t            rd_line;
  logic             hit_c;
  logic             req_c;
  logic             word_we_c;
  logic             line_we_c;
  logic             unused_addr_bits;

  assign a_s              = addr_t'(proc_addr[ADDR_W-1:2]);
  assign unused_addr_bits = ^proc_addr[1:0];

  dcache_array u_array (
    .clk      (clk),
    .rst      (rst),
    .idx      (a_s.idx),
    .rd_valid (rd_valid),
    .rd_dirty (rd_dirty),
    .rd_tag   (rd_tag),
    .rd_line  (rd_line),
    .word_we  (word_we_c),
    .wr_off   (a_s.off),
    .wr_word  (proc_wdata),
    .line_we  (line_we_c),
    .wr_tag   (a_s.tag),
    .wr_line  (line_t'(mem_rdata))
  );

  assign hit_c = rd_valid & (rd_tag == a_s.tag);
  assign req_c = proc_ren | proc_wen;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_n;
  end

  // Next state, array write strobes and processor-side outputs.
  // Write strobes are gated by rst so an aborted refill never lands.
  always_comb begin
    state_n    = state_q;
    word_we_c  = 1'b0;
    line_we_c  = 1'b0;
    proc_stall = req_c & (~hit_c | (state_q != IDLE));
    proc_rdata = '0;
    unique case (state_q)
      IDLE: begin
        if (req_c && hit_c) begin
          // ren+wen together is a write and returns no data.
          if (proc_wen) word_we_c  = ~rst;
          else          proc_rdata = rd_line[a_s.off];
        end else if (req_c) begin
          state_n = rd_dirty ? WRITEBACK : ALLOCATE;
        end
      end
      WRITEBACK: begin
        if (mem_ready) state_n = ALLOCATE;
      end
      ALLOCATE: begin
        if (mem_ready) begin
          line_we_c = ~rst;
          state_n   = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Memory-side outputs, registered off the next state so they line up
  // with the state they belong to; victim address/data captured on entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      mem_read  <= (state_n == ALLOCATE);
      mem_write <= (state_n == WRITEBACK);
      if (state_q == IDLE && state_n == WRITEBACK) begin
        mem_addr  <= {rd_tag, a_s.idx};
        mem_wdata <= LINE_W'(rd_line);
      end else if (state_n == ALLOCATE && state_q != ALLOCATE) begin
        mem_addr  <= proc_addr[ADDR_W-1:4];
        mem_wdata <= '0;
      end else if (state_n == IDLE) begin
        mem_addr  <= '0;
        mem_wdata <= '0;
      end
    end
  end

endmodule

// File: tb/tb_dcache.sv
// Directed self-checking bench for dcache with a small backing-memory model.
module tb_dcache;

  logic         clk;
  logic         rst;
  logic         proc_ren;
  logic         proc_wen;
  logic [31:0]  proc_addr;
  logic [31:0]  proc_wdata;
  logic         proc_stall;
  logic [31:0]  proc_rdata;
  logic         mem_read;
  logic         mem_write;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata;
  logic         mem_ready;

  int checks;
  int errors;

  // Per-access observations.
  int           acc_stalls;
  logic [31:0]  acc_rdata;
  bit           wb_seen;
  logic [27:0]  wb_addr;
  logic [127:0] wb_data;
  int           wb_cyc;
  bit           rd_seen;
  logic [27:0]  rd_addr;
  int           rd_cyc;
  bit           both_err;
  bit           rdata_nz;

  logic [127:0] mem_store [logic [27:0]];

  dcache dut (
    .clk        (clk),
    .rst        (rst),
    .proc_ren   (proc_ren),
    .proc_wen   (proc_wen),
    .proc_addr  (proc_addr),
    .proc_wdata (proc_wdata),
    .proc_stall (proc_stall),
    .proc_rdata (proc_rdata),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Untouched memory: word i = (i+1)*0x11111111 ^ ((blk^4) << 4).
  function automatic logic [127:0] blk_data(input logic [27:0] b);
    logic [127:0] d;
    if (mem_store.exists(b)) return mem_store[b];
    for (int i = 0; i < 4; i++)
      d[i*32 +: 32] = (32'h1111_1111 * 32'(i + 1)) ^ {b ^ 28'h4, 4'h0};
    return d;
  endfunction

  // One processor request, acting as memory until the cache stops stalling.
  task automatic do_access(input logic ren, input logic wen, input logic [31:0] addr,
                           input logic [31:0] wdata, input int lat_w, input int lat_r);
    int cw;
    int cr;
    bit done;
    cw = 0; cr = 0; done = 0;
    acc_stalls = 0; acc_rdata = 'x;
    wb_seen = 0; rd_seen = 0; both_err = 0; rdata_nz = 0;
    wb_cyc = -1; rd_cyc = -1;
    @(negedge clk);
    proc_ren = ren; proc_wen = wen; proc_addr = addr; proc_wdata = wdata;
    mem_ready = 1'b0;
    for (int cyc = 0; cyc < 100 && !done; cyc++) begin
      #1;
      if (!proc_stall) begin
        acc_rdata = proc_rdata;
        done = 1;
      end else begin
        acc_stalls++;
        if (proc_rdata !== 32'h0) rdata_nz = 1;
        if (mem_read && mem_write) both_err = 1;
        if (mem_write) begin
          if (!wb_seen) begin
            wb_seen = 1; wb_addr = mem_addr; wb_data = mem_wdata; wb_cyc = cyc;
          end
          cw++;
          if (cw == lat_w) begin
            mem_ready = 1'b1;
            mem_store[mem_addr] = mem_wdata;
          end
        end else if (mem_read) begin
          if (!rd_seen) begin
            rd_seen = 1; rd_addr = mem_addr; rd_cyc = cyc;
          end
          cr++;
          if (cr == lat_r) begin
            mem_ready = 1'b1;
            mem_rdata = blk_data(mem_addr);
          end
        end
        @(negedge clk);
        mem_ready = 1'b0;
      end
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL access_timeout addr=%h still stalled after 100 cycles", addr);
    end
    @(posedge clk);
    #1;
    proc_ren = 1'b0; proc_wen = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checks++; if (proc_stall !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b exp=0", proc_stall); end
    checks++; if (proc_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got=%h exp=0", proc_rdata); end
    checks++; if (mem_read !== 1'b0) begin errors++; $display("FAIL reset_mem_read got=%b exp=0", mem_read); end
    checks++; if (mem_write !== 1'b0) begin errors++; $display("FAIL reset_mem_write got=%b exp=0", mem_write); end
    checks++; if (mem_addr !== 28'h0) begin errors++; $display("FAIL reset_mem_addr got=%h exp=0", mem_addr); end
    checks++; if (mem_wdata !== 128'h0) begin errors++; $display("FAIL reset_mem_wdata got=%h exp=0", mem_wdata); end
  endtask

  task automatic test_read_miss;
    do_access(1'b1, 1'b0, 32'h0000_0040, 32'h0, 1, 3);
    checks++; if (acc_stalls !== 4) begin errors++; $display("FAIL miss_stalls got=%0d exp=4", acc_stalls); end
    checks++; if (rd_seen !== 1'b1 || rd_addr !== 28'h000_0004) begin errors++; $display("FAIL miss_rd_addr seen=%b got=%h exp=0000004", rd_seen, rd_addr); end
    checks++; if (wb_seen !== 1'b0) begin errors++; $display("FAIL miss_no_wb got=%b exp=0", wb_seen); end
    checks++; if (acc_rdata !== 32'h1111_1111) begin errors++; $display("FAIL miss_rdata got=%h exp=11111111", acc_rdata); end
    checks++; if (rdata_nz !== 1'b0) begin errors++; $display("FAIL miss_stall_rdata_nonzero got=%b exp=0", rdata_nz); end
  endtask

  task automatic test_read_hit;
    do_access(1'b1, 1'b0, 32'h0000_0044, 32'h0, 1, 1);
    checks++; if (acc_stalls !== 0) begin errors++; $display("FAIL hit1_stalls got=%0d exp=0", acc_stalls); end
    checks++; if (acc_rdata !== 32'h2222_2222) begin errors++; $display("FAIL hit1_rdata got=%h exp=22222222", acc_rdata); end
    do_access(1'b1, 1'b0, 32'h0000_004C, 32'h0, 1, 1);
    checks++; if (acc_rdata !== 32'h4444_4444 || acc_stalls !== 0) begin errors++; $display("FAIL hit3_rdata got=%h stalls=%0d exp=44444444/0", acc_rdata, acc_stalls); end
  endtask

  task automatic test_writeback;
    do_access(1'b0, 1'b1, 32'h0000_0048, 32'hDEAD_BEEF, 1, 1);
    checks++; if (acc_stalls !== 0) begin errors++; $display("FAIL wr_hit_stalls got=%0d exp=0", acc_stalls); end
    do_access(1'b1, 1'b0, 32'h0000_0848, 32'h0, 2, 3);
    checks++; if (wb_seen !== 1'b1 || wb_addr !== 28'h000_0004) begin errors++; $display("FAIL wb_addr seen=%b got=%h exp=0000004", wb_seen, wb_addr); end
    checks++; if (wb_data[95:64] !== 32'hDEAD_BEEF || wb_data[31:0] !== 32'h1111_1111) begin errors++; $display("FAIL wb_data got=%h exp w2=deadbeef w0=11111111", wb_data); end
    checks++; if (rd_seen !== 1'b1 || rd_addr !== 28'h000_0084 || rd_cyc <= wb_cyc) begin errors++; $display("FAIL wb_then_rd rd_addr=%h rd_cyc=%0d wb_cyc=%0d exp 0000084 after wb", rd_addr, rd_cyc, wb_cyc); end
    checks++; if (both_err !== 1'b0) begin errors++; $display("FAIL rd_wr_overlap got=%b exp=0", both_err); end
    checks++; if (acc_stalls !== 6) begin errors++; $display("FAIL dirty_miss_stalls got=%0d exp=6", acc_stalls); end
    checks++; if (acc_rdata !== 32'h3333_3B33) begin errors++; $display("FAIL dirty_miss_rdata got=%h exp=33333b33", acc_rdata); end
    // Line 4 is now clean; going back refetches the written-back block.
    do_access(1'b1, 1'b0, 32'h0000_0048, 32'h0, 1, 3);
    checks++; if (wb_seen !== 1'b0 || acc_stalls !== 4) begin errors++; $display("FAIL clean_refetch wb=%b stalls=%0d exp=0/4", wb_seen, acc_stalls); end
    checks++; if (acc_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL refetch_rdata got=%h exp=deadbeef", acc_rdata); end
  endtask

  task automatic test_write_miss;
    do_access(1'b0, 1'b1, 32'h0000_0010, 32'hCAFE_0001, 1, 2);
    checks++; if (acc_stalls !== 3 || wb_seen !== 1'b0) begin errors++; $display("FAIL wmiss stalls=%0d wb=%b exp=3/0", acc_stalls, wb_seen); end
    checks++; if (rd_addr !== 28'h000_0001) begin errors++; $display("FAIL wmiss_rd_addr got=%h exp=0000001", rd_addr); end
    do_access(1'b1, 1'b0, 32'h0000_0010, 32'h0, 1, 1);
    checks++; if (acc_rdata !== 32'hCAFE_0001 || acc_stalls !== 0) begin errors++; $display("FAIL wmiss_merge got=%h stalls=%0d exp=cafe0001/0", acc_rdata, acc_stalls); end
    do_access(1'b1, 1'b0, 32'h0000_0014, 32'h0, 1, 1);
    checks++; if (acc_rdata !== 32'h2222_2272) begin errors++; $display("FAIL wmiss_word1 got=%h exp=22222272", acc_rdata); end
    // Dirty bit must have been set: evicting forces a write-back.
    do_access(1'b1, 1'b0, 32'h0000_0810, 32'h0, 1, 1);
    checks++; if (wb_seen !== 1'b1 || wb_addr !== 28'h000_0001 || wb_data[31:0] !== 32'hCAFE_0001) begin errors++; $display("FAIL wmiss_dirty wb=%b addr=%h w0=%h exp 1/0000001/cafe0001", wb_seen, wb_addr, wb_data[31:0]); end
    checks++; if (acc_stalls !== 3 || acc_rdata !== 32'h1111_1941) begin errors++; $display("FAIL evict_read stalls=%0d rdata=%h exp=3/11111941", acc_stalls, acc_rdata); end
  endtask

  task automatic test_reset_abort;
    @(negedge clk);
    proc_ren = 1'b1; proc_wen = 1'b0; proc_addr = 32'h0000_0100;
    @(negedge clk);
    #1;
    checks++; if (mem_read !== 1'b1 || mem_addr !== 28'h000_0010) begin errors++; $display("FAIL abort_alloc mem_read=%b addr=%h exp=1/0000010", mem_read, mem_addr); end
    rst = 1'b1; proc_ren = 1'b0;
    @(negedge clk);
    rst = 1'b0; mem_ready = 1'b1; mem_rdata = {4{32'hFFFF_FFFF}};
    #1;
    checks++; if (mem_read !== 1'b0 || proc_stall !== 1'b0) begin errors++; $display("FAIL abort_idle mem_read=%b stall=%b exp=0/0", mem_read, proc_stall); end
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    checks++; if (mem_read !== 1'b0 || mem_write !== 1'b0) begin errors++; $display("FAIL abort_ready_ignored rd=%b wr=%b exp=0/0", mem_read, mem_write); end
    do_access(1'b1, 1'b0, 32'h0000_0100, 32'h0, 1, 2);
    checks++; if (acc_stalls !== 3 || rd_addr !== 28'h000_0010) begin errors++; $display("FAIL abort_remiss stalls=%0d addr=%h exp=3/0000010", acc_stalls, rd_addr); end
    checks++; if (acc_rdata !== 32'h1111_1051) begin errors++; $display("FAIL abort_rdata got=%h exp=11111051", acc_rdata); end
    do_access(1'b1, 1'b0, 32'h0000_0044, 32'h0, 1, 1);
    checks++; if (acc_stalls !== 2 || acc_rdata !== 32'h2222_2222) begin errors++; $display("FAIL reset_invalidates stalls=%0d rdata=%h exp=2/22222222", acc_stalls, acc_rdata); end
  endtask

  task automatic test_rw_both;
    do_access(1'b1, 1'b1, 32'h0000_0104, 32'h1234_5678, 1, 1);
    checks++; if (acc_stalls !== 0 || acc_rdata !== 32'h0) begin errors++; $display("FAIL rw_both stalls=%0d rdata=%h exp=0/0", acc_stalls, acc_rdata); end
    do_access(1'b1, 1'b0, 32'h0000_0104, 32'h0, 1, 1);
    checks++; if (acc_rdata !== 32'h1234_5678) begin errors++; $display("FAIL rw_both_written got=%h exp=12345678", acc_rdata); end
  endtask

  task automatic test_back_to_back;
    do_access(1'b0, 1'b1, 32'h0000_0108, 32'hA5A5_A5A5, 1, 1);
    do_access(1'b0, 1'b1, 32'h0000_010C, 32'h5A5A_5A5A, 1, 1);
    do_access(1'b1, 1'b0, 32'h0000_0108, 32'h0, 1, 1);
    checks++; if (acc_rdata !== 32'hA5A5_A5A5 || acc_stalls !== 0) begin errors++; $display("FAIL b2b_w2 got=%h stalls=%0d exp=a5a5a5a5/0", acc_rdata, acc_stalls); end
    do_access(1'b1, 1'b0, 32'h0000_010C, 32'h0, 1, 1);
    checks++; if (acc_rdata !== 32'h5A5A_5A5A) begin errors++; $display("FAIL b2b_w3 got=%h exp=5a5a5a5a", acc_rdata); end
    do_access(1'b1, 1'b0, 32'h0000_0100, 32'h0, 1, 1);
    checks++; if (acc_rdata !== 32'h1111_1051) begin errors++; $display("FAIL b2b_w0 got=%h exp=11111051", acc_rdata); end
  endtask

  initial begin
    checks = 0; errors = 0;
    rst = 1'b0; proc_ren = 1'b0; proc_wen = 1'b0;
    proc_addr = 32'h0; proc_wdata = 32'h0;
    mem_rdata = '0; mem_ready = 1'b0;
    test_reset;
    test_read_miss;
    test_read_hit;
    test_writeback;
    test_write_miss;
    test_reset_abort;
    test_rw_both;
    test_back_to_back;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
